// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared types and helpers for the RV32 data memory pipeline.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_pkg;

  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dm_ctrl_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [2:0]  ctrl;
    logic [1:0]  off;
    logic [31:0] data;
  } dmem_pipe_t;

  // Unsigned variants only exist for loads.
  function automatic logic dm_legal(input logic [2:0] ctrl, input logic we);
    logic ok;
    case (ctrl)
      DM_B, DM_H, DM_W: ok = 1'b1;
      DM_BU, DM_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] dm_extend(input logic [2:0] ctrl, input logic [1:0] off,
                                            input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = data[{off, 3'b000} +: 8];
    h = off[1] ? data[31:16] : data[15:0];
    case (ctrl)
      DM_B:    r = {{24{b[7]}}, b};
      DM_BU:   r = {24'b0, b};
      DM_H:    r = {{16{h[15]}}, h};
      DM_HU:   r = {16'b0, h};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_byte_ram.sv
`default_nettype none
// ============================================================================
// Module  : dmem_byte_ram
// Brief   : Four byte-lane synchronous RAM with a priority clear write port.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_byte_ram #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           clr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] clr_idx,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  localparam int c_IDX_W = $clog2(DEPTH_WORDS);

  logic [c_IDX_W-1:0] w_waddr;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;

  always_comb begin
    w_waddr = addr;
    w_be    = we ? be : 4'b0000;
    w_wdata = wdata;
    if (clr_en) begin
      w_waddr = clr_idx;
      w_be    = 4'b1111;
      w_wdata = '0;
    end
  end

  generate
    for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [7:0] r_mem [DEPTH_WORDS];
      logic [7:0] r_q;

      always_ff @(posedge clk) begin
        if (w_be[g]) r_mem[w_waddr] <= w_wdata[8*g +: 8];
        if (re)      r_q <= r_mem[addr];
      end

      assign rdata[8*g +: 8] = r_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/data_memory_pipe.sv
`default_nettype none
// ============================================================================
// Module  : data_memory_pipe
// Brief   : RV32 data memory with clear sequencer and fixed-latency responses.
// Revision: 1.0 - initial release
// ============================================================================
module data_memory_pipe
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int LATENCY      = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [2:0]            req_dm_ctrl,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy_clear
);

  localparam int                 c_IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DEPTH_WORDS - 1);
  localparam logic [0:0]         c_ST_CLEAR = 1'b0;
  localparam logic [0:0]         c_ST_READY = 1'b1;

  logic [0:0]         r_state;
  logic [c_IDX_W-1:0] r_clr_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= (CLEAR_ON_RST != 0) ? c_ST_CLEAR : c_ST_READY;
      r_clr_idx <= '0;
    end else if (r_state == c_ST_CLEAR) begin
      r_clr_idx <= r_clr_idx + 1'b1;
      if (r_clr_idx == c_LAST_IDX) r_state <= c_ST_READY;
    end
  end

  assign req_ready  = (r_state == c_ST_READY);
  assign busy_clear = (r_state == c_ST_CLEAR);

  logic [1:0] w_off;
  logic       w_accept;
  logic       w_out_of_range;
  logic       w_misalign;
  logic       w_err;
  logic [3:0] w_be;
  logic [31:0] w_wdata;

  assign w_off    = req_addr[1:0];
  assign w_accept = req_valid & req_ready;

  // Upper address bits must be zero before the word index is trusted.
  generate
    if (ADDR_WIDTH > c_IDX_W + 2) begin : g_range
      assign w_out_of_range = |req_addr[ADDR_WIDTH-1:c_IDX_W+2];
    end else begin : g_no_range
      assign w_out_of_range = 1'b0;
    end
  endgenerate

  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b0000;
    w_wdata    = req_wdata;
    case (req_dm_ctrl)
      DM_B, DM_BU: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{req_wdata[7:0]}};
      end
      DM_H, DM_HU: begin
        w_misalign = w_off[0];
        w_be       = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{req_wdata[15:0]}};
      end
      DM_W: begin
        w_misalign = |w_off;
        w_be       = 4'b1111;
      end
      default: ;
    endcase
  end

  assign w_err = w_out_of_range | w_misalign | !dm_legal(req_dm_ctrl, req_we);

  logic [31:0] w_ram_rdata;

  dmem_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk    (clk),
    .clr_en (busy_clear),
    .clr_idx(r_clr_idx),
    .we     (w_accept & req_we & !w_err),
    .be     (w_be),
    .re     (w_accept & !req_we & !w_err),
    .addr   (req_addr[c_IDX_W+1:2]),
    .wdata  (w_wdata),
    .rdata  (w_ram_rdata)
  );

  logic       r_v0;
  logic       r_err0;
  logic       r_ld0;
  logic [2:0] r_ctrl0;
  logic [1:0] r_off0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0    <= 1'b0;
      r_err0  <= 1'b0;
      r_ld0   <= 1'b0;
      r_ctrl0 <= '0;
      r_off0  <= '0;
    end else begin
      r_v0    <= w_accept;
      r_err0  <= w_err;
      r_ld0   <= !req_we;
      r_ctrl0 <= req_dm_ctrl;
      r_off0  <= w_off;
    end
  end

  dmem_pipe_t w_stage0;
  dmem_pipe_t w_last;

  // Stores and errors carry zero data so the extender naturally yields 0.
  always_comb begin
    w_stage0.valid = r_v0;
    w_stage0.err   = r_err0;
    w_stage0.ctrl  = r_ctrl0;
    w_stage0.off   = r_off0;
    w_stage0.data  = (r_ld0 && !r_err0) ? w_ram_rdata : '0;
  end

  generate
    if (LATENCY > 1) begin : g_pipe
      dmem_pipe_t r_pipe [LATENCY-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LATENCY - 1; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_stage0;
          for (int i = 1; i < LATENCY - 1; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign w_last = r_pipe[LATENCY-2];
    end else begin : g_no_pipe
      assign w_last = w_stage0;
    end
  endgenerate

  assign rsp_valid = w_last.valid;
  assign rsp_err   = w_last.valid & w_last.err;
  assign rsp_rdata = (w_last.valid && !w_last.err) ?
                     dm_extend(w_last.ctrl, w_last.off, w_last.data) : 32'h0;

endmodule
`default_nettype wire
